frame_pixel_streamer: RTL and testbench

//  Transmit side of the filter pixel stream: on start, reads one full frame from a

---
 rtl/frame_pixel_streamer.sv | 136 +++++++++++++
 tb/tb_frame_pixel_streamer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_pixel_streamer.sv
// Frame-buffer to filter pixel streamer: reads one frame in raster order and emits it
// with ready/valid back-pressure and sof/eol/eof markers, through a 2-entry output queue.
module frame_pixel_streamer #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 19
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic [DATA_WIDTH-1:0] pixel_out,
    output logic                  pixel_out_valid,
    input  logic                  pixel_out_ready,
    output logic                  sof,
    output logic                  eol,
    output logic                  eof,
    output logic                  busy,
    output logic                  done
);

    localparam int XW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int YW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(IMG_WIDTH * IMG_HEIGHT - 1);
    localparam logic [XW-1:0]         X_LAST    = XW'(IMG_WIDTH - 1);
    localparam logic [YW-1:0]         Y_LAST    = YW'(IMG_HEIGHT - 1);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN,
        DONE
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  vld_p1;
    logic [DATA_WIDTH-1:0] queue_p2 [2];
    logic [1:0]            q_count;
    logic [XW-1:0]         x;
    logic [YW-1:0]         y;
    logic [2:0]            occ;
    logic                  pop;
    logic                  rd_issue;
    logic                  last_beat;

    // Stage p0: read issue. The pop term lets a read go out in the same cycle a slot frees.
    assign pop       = pixel_out_valid & pixel_out_ready;
    assign occ       = {1'b0, q_count} + {2'b00, vld_p1};
    assign rd_issue  = (state == STREAM) && (occ < (3'd2 + {2'b00, pop}));
    assign mem_rd_en = rd_issue;
    assign mem_addr  = rd_addr;

    // Stage p2: queue head drives the sink; markers come from the transfer counters.
    assign pixel_out_valid = (q_count != 2'd0);
    assign last_beat       = (x == X_LAST) && (y == Y_LAST);
    assign pixel_out       = pixel_out_valid ? queue_p2[0] : '0;
    assign sof             = pixel_out_valid && (x == '0) && (y == '0);
    assign eol             = pixel_out_valid && (x == X_LAST);
    assign eof             = pixel_out_valid && last_beat;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            rd_addr <= '0;
            vld_p1  <= 1'b0;
            q_count <= 2'd0;
            x       <= '0;
            y       <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            vld_p1  <= rd_issue;
            q_count <= q_count + {1'b0, vld_p1} - {1'b0, pop};
            done    <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= STREAM;
                        busy    <= 1'b1;
                        rd_addr <= '0;
                    end
                end
                STREAM: begin
                    if (rd_issue) begin
                        if (rd_addr == LAST_ADDR) state <= DRAIN;
                        else rd_addr <= rd_addr + ADDR_WIDTH'(1);
                    end
                end
                DRAIN: begin
                    if (pop && last_beat) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
            if (pop) begin
                if (x == X_LAST) begin
                    x <= '0;
                    y <= (y == Y_LAST) ? '0 : y + YW'(1);
                end else begin
                    x <= x + XW'(1);
                end
            end
        end
    end

    // Stage p1 -> p2: returned read data enters the queue behind whatever remains after a pop.
    always_ff @(posedge clk) begin
        case ({vld_p1, pop})
            2'b10: begin
                if (q_count == 2'd0) queue_p2[0] <= mem_rd_data;
                else queue_p2[1] <= mem_rd_data;
            end
            2'b01: queue_p2[0] <= queue_p2[1];
            2'b11: begin
                if (q_count == 2'd1) begin
                    queue_p2[0] <= mem_rd_data;
                end else begin
                    queue_p2[0] <= queue_p2[1];
                    queue_p2[1] <= mem_rd_data;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_frame_pixel_streamer.sv
// Scoreboard bench for frame_pixel_streamer: a 4x3 instance and a 1x1 instance,
// each fed by a synchronous-read memory model returning addr+0x10.
module tb_frame_pixel_streamer;

    localparam int W = 4;
    localparam int H = 3;
    localparam int N = W * H;

    logic       clk = 1'b0;
    logic       reset;
    always #5 clk = ~clk;

    logic       start, mem_rd_en, pixel_out_valid, pixel_out_ready, sof, eol, eof, busy, done;
    logic [3:0] mem_addr;
    logic [7:0] mem_rd_data, pixel_out;

    logic       b_start, b_mem_rd_en, b_valid, b_ready, b_sof, b_eol, b_eof, b_busy, b_done;
    logic [0:0] b_mem_addr;
    logic [7:0] b_mem_rd_data, b_pixel;

    frame_pixel_streamer #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
        .clk(clk), .reset(reset), .start(start), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
        .mem_rd_data(mem_rd_data), .pixel_out(pixel_out), .pixel_out_valid(pixel_out_valid),
        .pixel_out_ready(pixel_out_ready), .sof(sof), .eol(eol), .eof(eof), .busy(busy), .done(done)
    );

    frame_pixel_streamer #(.IMG_WIDTH(1), .IMG_HEIGHT(1), .DATA_WIDTH(8), .ADDR_WIDTH(1)) dut_1x1 (
        .clk(clk), .reset(reset), .start(b_start), .mem_rd_en(b_mem_rd_en), .mem_addr(b_mem_addr),
        .mem_rd_data(b_mem_rd_data), .pixel_out(b_pixel), .pixel_out_valid(b_valid),
        .pixel_out_ready(b_ready), .sof(b_sof), .eol(b_eol), .eof(b_eof), .busy(b_busy), .done(b_done)
    );

    always @(posedge clk) begin
        if (mem_rd_en)   mem_rd_data   <= 8'(mem_addr) + 8'h10;
        if (b_mem_rd_en) b_mem_rd_data <= 8'(b_mem_addr) + 8'h10;
    end

    int pass_cnt = 0;
    int chk_cnt  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    logic [10:0] exp_q[$];
    logic [10:0] exp_b[$];
    logic [10:0] prev_beat, head;
    bit          mon_en = 1'b0;
    bit          prev_v, prev_r;
    int          exp_addr, issued, xfers, done_cnt = 0;

    // Scoreboard monitor for the 4x3 instance, sampling on the falling edge.
    always @(negedge clk) begin
        if (mon_en) begin
            if (mem_rd_en) begin
                chk("rd_addr", 32'(mem_addr), 32'(exp_addr));
                exp_addr++;
                issued++;
            end
            if (prev_v && !prev_r) begin
                chk("stall_valid", 32'(pixel_out_valid), 32'd1);
                chk("stall_beat", 32'({sof, eol, eof, pixel_out}), 32'(prev_beat));
            end
            if (pixel_out_valid && pixel_out_ready) begin
                xfers++;
                chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    head = exp_q.pop_front();
                    chk("beat", 32'({sof, eol, eof, pixel_out}), 32'(head));
                end
            end
            chk("occupancy", 32'((issued - xfers) <= 2), 32'd1);
            if (done) begin
                done_cnt++;
                chk("sb_empty_at_done", 32'(exp_q.size()), 32'd0);
            end
            prev_v    = pixel_out_valid;
            prev_r    = pixel_out_ready;
            prev_beat = {sof, eol, eof, pixel_out};
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pushes the expected frame and pulses start; returns one step into cycle 1.
    task automatic begin_frame();
        exp_q.delete();
        exp_addr = 0;
        issued   = 0;
        xfers    = 0;
        prev_v   = 1'b0;
        prev_r   = 1'b0;
        for (int i = 0; i < N; i++)
            exp_q.push_back({i == 0, (i % W) == W - 1, i == N - 1, 8'(i + 16)});
        mon_en = 1'b1;
        start  = 1'b1;
        step();
        start  = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc);
        bit found = 1'b0;
        for (int i = 0; i < max_cyc && !found; i++) begin
            if (done) found = 1'b1;
            step();
        end
        chk("done_seen", 32'(found), 32'd1);
    endtask

    initial begin
        int d0, n;
        bit seen;
        reset = 1'b1; start = 1'b0; pixel_out_ready = 1'b0; b_start = 1'b0; b_ready = 1'b1;
        step(); step();
        chk("rst_outs", 32'({mem_rd_en, pixel_out_valid, sof, eol, eof, busy, done}), 32'd0);
        chk("rst_addr_pix", 32'({mem_addr, pixel_out}), 32'd0);
        reset = 1'b0;
        step();

        // Basic frame, ready held high: exact cycle timing.
        pixel_out_ready = 1'b1;
        d0 = done_cnt;
        begin_frame();
        chk("c1_rd_en", 32'(mem_rd_en), 32'd1);
        chk("c1_addr", 32'(mem_addr), 32'd0);
        for (int c = 1; c <= 16; c++) begin
            chk($sformatf("valid_c%0d", c), 32'(pixel_out_valid), 32'(c >= 3 && c <= 14));
            chk($sformatf("done_c%0d", c), 32'(done), 32'(c == 15));
            chk($sformatf("busy_c%0d", c), 32'(busy), 32'(c >= 1 && c <= 15));
            step();
        end
        chk("t1_xfers", 32'(xfers), 32'(N));
        chk("t1_done_cnt", 32'(done_cnt - d0), 32'd1);

        // Ready pattern 1,0,0 repeating.
        d0 = done_cnt;
        begin_frame();
        for (int i = 0; i < 100 && !done; i++) begin
            pixel_out_ready = (i % 3 == 0);
            step();
        end
        chk("t2_done", 32'(done), 32'd1);
        pixel_out_ready = 1'b1;
        step();
        chk("t2_xfers", 32'(xfers), 32'(N));
        chk("t2_done_cnt", 32'(done_cnt - d0), 32'd1);

        // Long stall before the first transfer.
        pixel_out_ready = 1'b0;
        begin_frame();
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (pixel_out_valid) seen = 1'b1;
            else step();
        end
        chk("t3_valid_seen", 32'(seen), 32'd1);
        for (int i = 0; i < 20; i++) step();
        chk("t3_issued", 32'(issued), 32'd2);
        chk("t3_pixel", 32'(pixel_out), 32'h10);
        pixel_out_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            chk($sformatf("t3_stream%0d", i), 32'(pixel_out_valid), 32'd1);
            step();
        end
        chk("t3_done", 32'(done), 32'd1);
        step();
        chk("t3_xfers", 32'(xfers), 32'(N));

        // Start re-pulsed mid-frame.
        d0 = done_cnt;
        begin_frame();
        for (int i = 0; i < 4; i++) step();
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done(40);
        for (int i = 0; i < 4; i++) step();
        chk("t4_done_cnt", 32'(done_cnt - d0), 32'd1);
        chk("t4_xfers", 32'(xfers), 32'(N));
        chk("t4_idle", 32'({busy, mem_rd_en, pixel_out_valid}), 32'd0);

        // Reset on the 5th transfer.
        begin_frame();
        n = 0;
        for (int i = 0; i < 40 && n < 5; i++) begin
            if (pixel_out_valid && pixel_out_ready) n++;
            if (n < 5) step();
        end
        chk("t5_reached_5th", 32'(n), 32'd5);
        mon_en = 1'b0;
        reset  = 1'b1;
        #1;
        chk("t5_rst_outs", 32'({mem_rd_en, pixel_out_valid, sof, eol, eof, busy, done}), 32'd0);
        chk("t5_rst_addr_pix", 32'({mem_addr, pixel_out}), 32'd0);
        step(); step();
        reset = 1'b0;
        step();
        chk("t5_no_done", 32'({busy, done, pixel_out_valid}), 32'd0);
        d0 = done_cnt;
        begin_frame();
        wait_done(40);
        step();
        chk("t5_xfers", 32'(xfers), 32'(N));
        chk("t5_done_cnt", 32'(done_cnt - d0), 32'd1);
        mon_en = 1'b0;

        // 1x1 frame.
        exp_b.push_back({1'b1, 1'b1, 1'b1, 8'h10});
        b_start = 1'b1;
        step();
        b_start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (b_valid) seen = 1'b1;
            else step();
        end
        chk("b_valid_seen", 32'(seen), 32'd1);
        head = exp_b.pop_front();
        chk("b_beat", 32'({b_sof, b_eol, b_eof, b_pixel}), 32'(head));
        step();
        chk("b_done", 32'(b_done), 32'd1);
        chk("b_valid_after", 32'(b_valid), 32'd0);
        step();
        chk("b_idle", 32'({b_busy, b_done}), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", pass_cnt, chk_cnt);
        $fatal(1, "watchdog");
    end

endmodule
